// File: rtl/iq_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// iq_pkg : shared widths, types and helpers for the instruction fetch queue
// Revision: 1.0
// ---------------------------------------------------------------------------
package iq_pkg;

  localparam int INST_W_DEF = 32;
  localparam int DEPTH_DEF  = 64;

  // Ceiling log2, usable in constant expressions; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  localparam int PTR_W_DEF = clog2(DEPTH_DEF);
  localparam int CNT_W_DEF = PTR_W_DEF + 1;

  typedef logic [0:INST_W_DEF-1] inst_t;

endpackage
`default_nettype wire

// File: rtl/iq_storage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// iq_storage : DEPTH x INST_W register array, FETCH_W wrapped write ports and
//              ISSUE_W wrapped read ports at consecutive addresses
// Revision: 1.0
// ---------------------------------------------------------------------------
module iq_storage
  import iq_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2,
  parameter int INST_W  = INST_W_DEF
) (
  input  logic                         clk,
  input  logic [clog2(DEPTH)-1:0]      wr_ptr,
  input  logic [FETCH_W-1:0]           wr_en,
  input  logic [0:FETCH_W*INST_W-1]    wr_data,
  input  logic [clog2(DEPTH)-1:0]      rd_ptr,
  output logic [0:ISSUE_W*INST_W-1]    rd_data
);

  localparam int PTR_W = clog2(DEPTH);

  logic [0:INST_W-1] mem [DEPTH];

  // Port addresses wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    for (int k = 0; k < FETCH_W; k++) begin
      if (wr_en[k]) mem[wr_ptr + PTR_W'(k)] <= wr_data[k*INST_W +: INST_W];
    end
  end

  for (genvar k = 0; k < ISSUE_W; k++) begin : g_rd
    assign rd_data[k*INST_W +: INST_W] = mem[rd_ptr + PTR_W'(k)];
  end

endmodule
`default_nettype wire

// File: rtl/inst_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// inst_queue : multi-write / multi-issue instruction fetch queue with flush
//              and occupancy tracking. Optional macro IQ_BYPASS_EN enables
//              same-cycle bypass of fetch data into an empty queue.
// Revision: 1.0
// ---------------------------------------------------------------------------
module inst_queue
  import iq_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2,
  parameter int INST_W  = INST_W_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [clog2(FETCH_W+1)-1:0]    fetchCnt,
  input  logic [0:FETCH_W*INST_W-1]      fetchData,
  output logic                           fetchReady,
  output logic [ISSUE_W-1:0]             issueValid,
  output logic [0:ISSUE_W*INST_W-1]      issueInst,
  input  logic [clog2(ISSUE_W+1)-1:0]    issueTake,
  output logic [clog2(DEPTH):0]          count
);

  localparam int PTR_W  = clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int FCNT_W = clog2(FETCH_W + 1);
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - FETCH_W);

  logic [PTR_W-1:0]          head;
  logic [PTR_W-1:0]          tail;
  logic                      accept;
  logic                      bypass;
  logic [CNT_W-1:0]          written;
  logic [CNT_W-1:0]          avail;
  logic [CNT_W-1:0]          take;
  logic [CNT_W-1:0]          eff;
  logic [FETCH_W-1:0]        wr_en;
  logic [0:ISSUE_W*INST_W-1] rd_data;

  // Ready looks at registered occupancy only, never at this cycle's take.
  assign fetchReady = (count <= READY_MAX);
  assign accept     = (fetchCnt != '0) && fetchReady;
  assign written    = accept ? CNT_W'(fetchCnt) : '0;

`ifdef IQ_BYPASS_EN
  assign bypass = accept && (count == '0);
`else
  assign bypass = 1'b0;
`endif

  assign avail = bypass ? written : count;
  assign take  = CNT_W'(issueTake);
  assign eff   = (take > avail) ? avail : take;

  for (genvar k = 0; k < FETCH_W; k++) begin : g_wen
    assign wr_en[k] = accept && (FCNT_W'(k) < fetchCnt);
  end

  iq_storage #(
    .DEPTH   (DEPTH),
    .FETCH_W (FETCH_W),
    .ISSUE_W (ISSUE_W),
    .INST_W  (INST_W)
  ) u_storage (
    .clk     (clk),
    .wr_ptr  (tail),
    .wr_en   (wr_en),
    .wr_data (fetchData),
    .rd_ptr  (head),
    .rd_data (rd_data)
  );

  // A bypassed group is stored whole and head skips its taken part, which
  // leaves the same live entries as storing only the untaken remainder.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(eff);
      tail  <= tail + PTR_W'(written);
      count <= count + written - eff;
    end
  end

  always_comb begin
    issueValid = '0;
    issueInst  = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      if (CNT_W'(k) < count) begin
        issueValid[k]                  = 1'b1;
        issueInst[k*INST_W +: INST_W]  = rd_data[k*INST_W +: INST_W];
      end
    end
`ifdef IQ_BYPASS_EN
    if (bypass) begin
      for (int k = 0; k < ISSUE_W && k < FETCH_W; k++) begin
        if (FCNT_W'(k) < fetchCnt) begin
          issueValid[k]                 = 1'b1;
          issueInst[k*INST_W +: INST_W] = fetchData[k*INST_W +: INST_W];
        end
      end
    end
`endif
  end

endmodule
`default_nettype wire
